// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_CONSUMERS requesters,
// with a per-transaction watchdog that turns a silent memory into an error response.
module mem_rr_arbiter #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CONSUMERS-1:0]                 consumer_error,
    input  logic [NUM_CONSUMERS-1:0]                 error_clear,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready,
    output logic                                     busy
);
    localparam int   IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int   CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic WR_EN = (WRITE_ENABLE != 0);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                       cur_q, cur_d;
    logic [CNT_W-1:0]                       wdog_q, wdog_d;
    logic                                   mem_read_valid_q, mem_read_valid_d;
    logic                                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]                   mem_read_address_q, mem_read_address_d;
    logic [ADDR_BITS-1:0]                   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]                   mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]               rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]               wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0]               error_q, error_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic                                   grant_found;
    logic                                   grant_is_read;
    logic [IDX_W-1:0]                       grant_idx;
    logic [IDX_W-1:0]                       grant_next;
    logic [IDX_W-1:0]                       sidx;
    int unsigned                            scan_idx;
    logic [CNT_W-1:0]                       wdog_inc;

    // First requester at or after rr_ptr wins; a read beats a write from the same consumer.
    always_comb begin
        grant_found   = 1'b0;
        grant_is_read = 1'b0;
        grant_idx     = '0;
        grant_next    = '0;
        scan_idx      = 0;
        sidx          = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            scan_idx = (32'(rr_ptr_q) + unsigned'(i)) % unsigned'(NUM_CONSUMERS);
            sidx     = IDX_W'(scan_idx);
            if (!grant_found && (consumer_read_valid[sidx] ||
                                 (WR_EN && consumer_write_valid[sidx]))) begin
                grant_found   = 1'b1;
                grant_is_read = consumer_read_valid[sidx];
                grant_idx     = sidx;
                grant_next    = (sidx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : sidx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        cur_d               = cur_q;
        wdog_d              = wdog_q;
        wdog_inc            = wdog_q + 1'b1;
        mem_read_valid_d    = mem_read_valid_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        rd_ready_d          = rd_ready_q;
        wr_ready_d          = wr_ready_q;
        rd_data_d           = rd_data_q;
        error_d             = error_q & ~error_clear;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    cur_d    = grant_idx;
                    rr_ptr_d = grant_next;
                    wdog_d   = '0;
                    if (grant_is_read) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[grant_idx];
                        state_d            = READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[grant_idx];
                        mem_write_data_d    = consumer_write_data[grant_idx];
                        state_d             = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                wdog_d = wdog_inc;
                if (mem_read_ready) begin
                    mem_read_valid_d  = 1'b0;
                    rd_ready_d[cur_q] = 1'b1;
                    rd_data_d[cur_q]  = mem_read_data;
                    state_d           = READ_RELAYING;
                end else if (wdog_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    mem_read_valid_d  = 1'b0;
                    rd_ready_d[cur_q] = 1'b1;
                    rd_data_d[cur_q]  = '1;
                    error_d[cur_q]    = 1'b1;
                    state_d           = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                wdog_d = wdog_inc;
                if (mem_write_ready) begin
                    mem_write_valid_d = 1'b0;
                    wr_ready_d[cur_q] = 1'b1;
                    state_d           = WRITE_RELAYING;
                end else if (wdog_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    mem_write_valid_d = 1'b0;
                    wr_ready_d[cur_q] = 1'b1;
                    error_d[cur_q]    = 1'b1;
                    state_d           = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[cur_q]) begin
                    rd_ready_d[cur_q] = 1'b0;
                    state_d           = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[cur_q]) begin
                    wr_ready_d[cur_q] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            cur_q               <= '0;
            wdog_q              <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            rd_ready_q          <= '0;
            wr_ready_q          <= '0;
            rd_data_q           <= '0;
            error_q             <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            cur_q               <= cur_d;
            wdog_q              <= wdog_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            rd_ready_q          <= rd_ready_d;
            wr_ready_q          <= wr_ready_d;
            rd_data_q           <= rd_data_d;
            error_q             <= error_d;
        end
    end

    // Read-only ports tie the whole write side low regardless of register contents.
    assign mem_write_valid      = WR_EN ? mem_write_valid_q   : 1'b0;
    assign mem_write_address    = WR_EN ? mem_write_address_q : '0;
    assign mem_write_data       = WR_EN ? mem_write_data_q    : '0;
    assign consumer_write_ready = WR_EN ? wr_ready_q          : '0;

    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;
    assign consumer_read_ready = rd_ready_q;
    assign consumer_read_data  = rd_data_q;
    assign consumer_error      = error_q;
    assign busy                = (state_q != IDLE);
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: round-robin order, read/write priority,
// watchdog timeout and sticky error, ready-vs-timeout tie, asynchronous reset.
module tb_mem_rr_arbiter;
    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;
    localparam int TO = 4;

    logic                   clk   = 1'b0;
    logic                   reset = 1'b0;
    logic [NC-1:0]          rv, rrdy, wv, wrdy, err, eclr;
    logic [NC-1:0][AB-1:0]  raddr, waddr;
    logic [NC-1:0][DB-1:0]  rdata, wdata;
    logic                   mrv, mwv, mrr, mwr, busy;
    logic [AB-1:0]          mra, mwa;
    logic [DB-1:0]          mrd, mwd;
    logic                   rd_auto, rd_force, wr_auto;
    int                     checks   = 0;
    int                     failures = 0;

    mem_rr_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .WRITE_ENABLE(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(rrdy), .consumer_read_data(rdata),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(wrdy),
        .consumer_error(err), .error_clear(eclr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: answers the cycle after a request unless ready is forced by hand.
    assign mrr = rd_auto ? mrv : rd_force;
    assign mrd = 16'(mra) + 16'h0100;
    assign mwr = wr_auto & mwv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(input string tag);
        int n;
        n = 0;
        while (!mrv && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(mrv), 32'd1);
    endtask

    task automatic serve(input int k, input logic [7:0] addr, input bit drop_all);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        wait_rv($sformatf("grant%0d_valid", k));
        chk($sformatf("grant%0d_addr", k), 32'(mra), 32'(addr));
        tick();
        chk($sformatf("rd%0d_ready", k), 32'(rrdy), 32'(onehot));
        chk($sformatf("rd%0d_data", k), 32'(rdata[k]), 32'(addr) + 32'h100);
        if (drop_all) rv = '0;
        else rv[k] = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rv = '0; wv = '0; eclr = '0;
        raddr = '0; waddr = '0; wdata = '0;
        rd_auto = 1'b1; rd_force = 1'b0; wr_auto = 1'b1;

        #12;
        chk("rst_mem_read_valid", 32'(mrv), 32'd0);
        chk("rst_mem_write_valid", 32'(mwv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({rrdy, wrdy, err}), 32'd0);
        reset = 1'b1;

        // All four consumers stream reads; grants must rotate 0,1,2,3,0.
        raddr = {8'h13, 8'h12, 8'h11, 8'h10};
        rv    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            serve(i % 4, 8'(8'h10 + i % 4), i == 4);
            if (i < 4) rv[i % 4] = 1'b1;
        end

        // Grant 1 leaves rr_ptr at 2, so 3 beats 0.
        raddr[1] = 8'h31;
        rv = 4'b0010;
        serve(1, 8'h31, 1'b1);
        raddr[0] = 8'h40;
        raddr[3] = 8'h43;
        rv = 4'b1001;
        serve(3, 8'h43, 1'b0);
        serve(0, 8'h40, 1'b1);

        // Read and write from the same consumer: read first, write on a later grant.
        raddr[1] = 8'h20;
        waddr[1] = 8'h21;
        wdata[1] = 16'hBEEF;
        rv = 4'b0010;
        wv = 4'b0010;
        serve(1, 8'h20, 1'b0);
        n = 0;
        while (!mwv && n < 20) begin
            tick();
            n++;
        end
        chk("wr_grant_valid", 32'(mwv), 32'd1);
        chk("wr_grant_addr", 32'(mwa), 32'h21);
        chk("wr_grant_data", 32'(mwd), 32'hBEEF);
        chk("wr_no_read_overlap", 32'(mrv), 32'd0);
        tick();
        chk("wr_ready", 32'(wrdy), 32'b0010);
        wv = '0;
        tick();
        chk("wr_ready_clear", 32'(wrdy), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);

        // Silent memory on consumer 2: timeout after 4 waiting cycles.
        rd_auto = 1'b0;
        raddr[2] = 8'h50;
        rv = 4'b0100;
        wait_rv("to_grant");
        repeat (3) tick();
        chk("to_not_early", 32'(rrdy), 32'd0);
        chk("to_still_requesting", 32'(mrv), 32'd1);
        tick();
        chk("to_ready", 32'(rrdy), 32'b0100);
        chk("to_data", 32'(rdata[2]), 32'hFFFF);
        chk("to_error", 32'(err), 32'b0100);
        chk("to_drop_valid", 32'(mrv), 32'd0);
        rv = '0;
        tick();
        chk("to_error_sticky", 32'(err), 32'b0100);
        eclr[2] = 1'b1;
        tick();
        eclr = '0;
        chk("to_error_cleared", 32'(err), 32'd0);

        // Ready arrives on the very cycle the watchdog would fire.
        raddr[3] = 8'h60;
        rv = 4'b1000;
        wait_rv("tie_grant");
        repeat (3) tick();
        rd_force = 1'b1;
        tick();
        chk("tie_ready", 32'(rrdy), 32'b1000);
        chk("tie_data", 32'(rdata[3]), 32'h0160);
        chk("tie_no_error", 32'(err), 32'd0);
        rd_force = 1'b0;
        rv = '0;
        tick();

        // Asynchronous reset during READ_WAITING.
        raddr[1] = 8'h70;
        rv = 4'b0010;
        wait_rv("ar_grant");
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mem_read_valid", 32'(mrv), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'({rrdy, wrdy}), 32'd0);
        chk("ar_rd_data_cleared", 32'(rdata[3]), 32'd0);
        #2;
        reset = 1'b1;
        rd_auto = 1'b1;
        raddr[0] = 8'h80;
        raddr[2] = 8'h82;
        rv = 4'b0101;
        serve(0, 8'h80, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
